// File: rtl/shadow_commit_ctrl.sv
// Sequencer between a staging buffer and a main/shadow register pair.
// It handles commit (with an optional automatic snapshot), snapshot, restore and shadow preload.
module shadow_commit_ctrl #(
  parameter int WIDTH     = 32,
  parameter bit AUTO_SNAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_valid,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_wr_ready,
  input  logic             i_sh_wr_valid,
  input  logic [WIDTH-1:0] i_sh_wr_data,
  input  logic             i_commit_req,
  input  logic             i_snap_req,
  input  logic             i_restore_req,
  input  logic [WIDTH-1:0] i_shadow_data_out,
  output logic             o_main_load_en,
  output logic [WIDTH-1:0] o_main_data_in,
  output logic             o_shadow_capture_en,
  output logic             o_shadow_load_en,
  output logic [WIDTH-1:0] o_shadow_data_in,
  output logic             o_busy,
  output logic             o_pending,
  output logic             o_commit_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_RESTORE = 3'd3;
  localparam logic [2:0] S_PRELOAD = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic             r_cap_commit;
  logic             w_next_cap_commit;
  logic [WIDTH-1:0] r_staged;
  logic             r_pending;
  logic [WIDTH-1:0] r_pre_data;
  logic             r_cmt_f;
  logic             r_snp_f;
  logic             r_rst_f;
  logic             r_pre_f;
  logic             r_commit_done;

  logic w_cmt;
  logic w_snp;
  logic w_rst;
  logic w_pre;
  logic w_svc_cmt;
  logic w_svc_snp;
  logic w_svc_rst;
  logic w_svc_pre;
  logic w_drop_cmt;

  assign w_cmt = r_cmt_f | i_commit_req;
  assign w_snp = r_snp_f | i_snap_req;
  assign w_rst = r_rst_f | i_restore_req;
  assign w_pre = r_pre_f | i_sh_wr_valid;

  // A commit with nothing staged is dropped, but lower-priority work may still start that same cycle.
  always_comb begin
    w_next_state      = r_state;
    w_next_cap_commit = r_cap_commit;
    w_svc_cmt         = 1'b0;
    w_svc_snp         = 1'b0;
    w_svc_rst         = 1'b0;
    w_svc_pre         = 1'b0;
    w_drop_cmt        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rst) begin
          w_next_state = S_RESTORE;
          w_svc_rst    = 1'b1;
        end else if (w_cmt && r_pending) begin
          w_svc_cmt = 1'b1;
          if (AUTO_SNAP) begin
            w_next_state      = S_CAPTURE;
            w_next_cap_commit = 1'b1;
          end else begin
            w_next_state = S_LOAD;
          end
        end else begin
          w_drop_cmt = w_cmt;
          if (w_pre) begin
            w_next_state = S_PRELOAD;
            w_svc_pre    = 1'b1;
          end else if (w_snp) begin
            w_next_state      = S_CAPTURE;
            w_next_cap_commit = 1'b0;
            w_svc_snp         = 1'b1;
          end
        end
      end
      S_CAPTURE: w_next_state = r_cap_commit ? S_LOAD : S_IDLE;
      S_LOAD:    w_next_state = S_IDLE;
      S_RESTORE: w_next_state = S_IDLE;
      S_PRELOAD: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cap_commit  <= 1'b0;
      r_commit_done <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cap_commit  <= w_next_cap_commit;
      r_commit_done <= (r_state == S_LOAD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmt_f <= 1'b0;
      r_snp_f <= 1'b0;
      r_rst_f <= 1'b0;
      r_pre_f <= 1'b0;
    end else begin
      r_cmt_f <= w_cmt & ~(w_svc_cmt | w_drop_cmt);
      r_snp_f <= w_snp & ~w_svc_snp;
      r_rst_f <= w_rst & ~w_svc_rst;
      r_pre_f <= w_pre & ~w_svc_pre;
    end
  end

  // Pending is always set throughout LOAD, so a new write can never collide with the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_staged  <= '0;
      r_pending <= 1'b0;
    end else if (r_state == S_LOAD) begin
      r_pending <= 1'b0;
    end else if (i_wr_valid && !r_pending) begin
      r_staged  <= i_wr_data;
      r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre_data <= '0;
    end else if (i_sh_wr_valid) begin
      r_pre_data <= i_sh_wr_data;
    end
  end

  assign o_wr_ready          = ~r_pending;
  assign o_pending           = r_pending;
  assign o_busy              = (r_state != S_IDLE);
  assign o_commit_done       = r_commit_done;
  assign o_shadow_capture_en = (r_state == S_CAPTURE);
  assign o_shadow_load_en    = (r_state == S_PRELOAD);
  assign o_main_load_en      = (r_state == S_LOAD) || (r_state == S_RESTORE);
  assign o_main_data_in      = (r_state == S_LOAD)    ? r_staged :
                               (r_state == S_RESTORE) ? i_shadow_data_out : '0;
  assign o_shadow_data_in    = (r_state == S_PRELOAD) ? r_pre_data : '0;

endmodule

// File: doc/shadow_commit_ctrl.md
SHADOW_COMMIT_CTRL -- requirements
Module: shadow_commit_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: data width; SHALL match the downstream shadow register's width.
REQ-002 Parameter AUTO_SNAP, default 1: when 1, each commit SHALL capture main into shadow before loading main.
REQ-003 clk  in  1: single clock; all logic SHALL be on the rising edge.
REQ-004 rst_n  in  1: reset, asynchronous and active-low.
REQ-005 wr_valid  in  1; wr_data  in  WIDTH; wr_ready  out  1: staging write handshake.
REQ-006 sh_wr_valid  in  1; sh_wr_data  in  WIDTH: shadow preload request; no ready, latched (REQ-015).
REQ-007 commit_req, snap_req, restore_req  in  1 each: single-cycle request pulses.
REQ-008 shadow_data_out  in  WIDTH: current shadow value fed back from the shadow register.
REQ-009 main_load_en  out  1; main_data_in  out  WIDTH: drive the shadow register's main port.
REQ-010 shadow_capture_en, shadow_load_en  out  1; shadow_data_in  out  WIDTH: drive the shadow port.
REQ-011 busy  out  1 (state != IDLE); pending  out  1 (staging full); commit_done  out  1 (pulse).

Function
REQ-012 Staging: one-entry buffer; wr_ready = !pending; on wr_valid&&wr_ready, staged <= wr_data and pending <= 1 at the edge.
REQ-013 FSM states IDLE, CAPTURE, LOAD, RESTORE, PRELOAD; outputs SHALL be Moore-decoded from state only.
REQ-014 Requests SHALL be latched into one-deep flags (cmt_f, snp_f, rst_f, pre_f) in any state; a repeat while its flag is set is merged.
REQ-015 sh_wr_valid SHALL set pre_f and register sh_wr_data into pre_data; a new sh_wr_valid while pre_f is set overwrites pre_data.
REQ-016 IDLE arbitration, evaluated on flags plus same-cycle request inputs, priority: restore > commit (only if pending) > preload > snap.
REQ-017 commit_req with pending=0 SHALL be discarded (flag cleared, no state change, no commit_done).
REQ-018 Commit: IDLE -> CAPTURE (only if AUTO_SNAP=1) -> LOAD -> IDLE; the request seen in IDLE at cycle N enters its first state at N+1.
REQ-019 CAPTURE: shadow_capture_en=1 for exactly one cycle.
REQ-020 LOAD: main_load_en=1, main_data_in=staged for one cycle; pending SHALL clear at the end of LOAD.
REQ-021 commit_done SHALL be 1 for exactly the one cycle following LOAD.
REQ-022 RESTORE: main_load_en=1, main_data_in=shadow_data_out (combinational pass-through) for one cycle; pending and staged unchanged.
REQ-023 PRELOAD: shadow_load_en=1, shadow_data_in=pre_data for one cycle.
REQ-024 snap_req serviced in IDLE: CAPTURE for one cycle, then IDLE; no commit_done.
REQ-025 Each serviced flag SHALL clear on entry to its first state; unserviced flags persist.
REQ-026 Outside the active states: main_load_en, shadow_capture_en and shadow_load_en SHALL be 0, and main_data_in/shadow_data_in SHALL be 0.
REQ-027 Never more than one of main_load_en, shadow_capture_en, shadow_load_en SHALL be high in a cycle, except that none may be high.
REQ-028 A write handshake in the same cycle as LOAD SHALL NOT occur (wr_ready=0); the write SHALL be accepted from the next cycle on.

Reset
REQ-029 On rst_n=0: state=IDLE, staged=0, pre_data=0, all flags=0, pending=0, busy=0, commit_done=0, all enables and data outputs 0, wr_ready=1.
REQ-030 Reset asserted mid-sequence SHALL abort immediately; latched requests SHALL be dropped; no partial enable pulse SHALL follow release.

Verification
REQ-031 Write 0xA5A5A5A5, then commit_req at N (AUTO_SNAP=1) -> capture_en @N+1, main_load_en with 0xA5A5A5A5 @N+2, commit_done @N+3, pending 0.
REQ-032 commit_req with pending=0 -> no enables and no commit_done for 5 cycles; busy stays 0.
REQ-033 restore_req and commit_req in the same cycle with pending=1 -> RESTORE first (main_data_in = shadow_data_out, e.g. 0x12345678), then the commit sequence; commit_done once.
REQ-034 sh_wr_valid 0xDEADBEEF while busy in a commit -> shadow_load_en with 0xDEADBEEF one cycle after commit_done's IDLE cycle arbitration.
REQ-035 Second write while pending=1 -> wr_ready=0 and staged unchanged; write accepted the cycle after LOAD.
REQ-036 rst_n low during CAPTURE -> all outputs 0 asynchronously; after release there is no LOAD, pending=0 and wr_ready=1.
